// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding and default widths for the memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {IDLE, ISSUE} state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side handshakes and memory-side bus of the arbiter.
// The lock inputs exist only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [1:0] req, we, gnt, rvalid;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
`ifdef MEM_ARB_LOCK_EN
  logic [1:0] lock;
`endif
  logic mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input req, we, addr, wdata, mem_rdata,
`ifdef MEM_ARB_LOCK_EN
    input lock,
`endif
    output gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req, we, addr, wdata, mem_rdata,
`ifdef MEM_ARB_LOCK_EN
    output lock,
`endif
    input gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: one-hot winner of two requesters; an active owner excludes the other side.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       own_vld_i,
  input  logic       own_i,
  output logic [1:0] pick_o
);
  always_comb
    pick_o = own_vld_i ? req_i & (own_i ? 2'b10 : 2'b01)
           : &req_i   ? (last_i ? 2'b01 : 2'b10)
           : req_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of two requesters onto one memory, two cycles per access.
// Define MEM_ARB_LOCK_EN to let a requester keep ownership across grants via lock.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [1:0] pick, gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic win, start, win_q, win_d, last_q, last_d, rd_q, rd_d, wr_q, wr_d, own_vld, own_id;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  assign win = pick[1];
  assign start = state_q == IDLE && |pick;
`ifdef MEM_ARB_LOCK_EN
  logic own_q, own_d, own_vld_q, own_vld_d, lk_q, lk_d;
  // ownership lapses as soon as the owner shows neither req nor lock while idle
  assign own_id = own_q;
  assign own_vld = own_vld_q & (bus.req[own_q] | bus.lock[own_q]);
  always_comb begin
    own_d = state_q == ISSUE ? win_q : own_q;
    own_vld_d = state_q == ISSUE ? lk_q : own_vld;
    lk_d = start ? bus.lock[win] : lk_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      own_q <= 1'b0;
      own_vld_q <= 1'b0;
      lk_q <= 1'b0;
    end else begin
      own_q <= own_d;
      own_vld_q <= own_vld_d;
      lk_q <= lk_d;
    end
`else
  assign own_id = 1'b0;
  assign own_vld = 1'b0;
`endif
  rr_pick2 u_pick (
    .req_i(bus.req),
    .last_i(last_q),
    .own_vld_i(own_vld),
    .own_i(own_id),
    .pick_o(pick)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rvalid_q <= '0;
      rdata_q <= '{default: '0};
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      win_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      win_q <= win_d;
      last_q <= last_d;
    end
  always_comb state_d = start ? ISSUE : IDLE;
  // last-granted only moves once the access has really been issued
  always_comb begin
    gnt_d = start ? pick : 2'b00;
    rd_d = start & ~bus.we[win];
    wr_d = start & bus.we[win];
    addr_d = start ? bus.addr[win] : addr_q;
    wdata_d = start ? bus.wdata[win] : wdata_q;
    win_d = start ? win : win_q;
    last_d = state_q == ISSUE ? win_q : last_q;
    rvalid_d = state_q == ISSUE && rd_q ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    rdata_d = rdata_q;
    rdata_d[win_q] = |rvalid_d ? bus.mem_rdata : rdata_q[win_q];
  end
  assign bus.gnt = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata = rdata_q;
  assign bus.mem_read = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random requests against a transaction-level arbiter model.
// Build with MEM_ARB_LOCK_EN to add the lock scenario.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  typedef struct packed {
    logic we;
    logic lk;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  txn_t q [2][$];
  int passed = 0, total = 0, cyc = 0, last_m, owner_m;
  int glog[$], gcyc[$];
  logic [DW-1:0] rlog[$];
  logic [1:0] e_gnt, e_rv, p_rv;
  logic e_rd, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, p_data;
  logic [DW-1:0] e_rdata [2];
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic lock_of(int i);
`ifdef MEM_ARB_LOCK_EN
    return bus.lock[i];
`else
    return 1'b0 & i[0];
`endif
  endfunction
  task automatic model_reset();
    e_gnt = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_rv = 0; p_rv = 0;
    e_rdata[0] = 0; e_rdata[1] = 0; last_m = 1; owner_m = -1;
  endtask
  // each access: grant+strobe in the cycle after sampling, read data one cycle later
  task automatic predict();
    logic [1:0] r;
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_rv = p_rv; p_rv = 0;
    for (int i = 0; i < 2; i++) if (e_rv[i]) e_rdata[i] = p_data;
    e_rd = 0; e_wr = 0;
    if (e_gnt != 0) begin
      e_gnt = 0;
      return;
    end
    r = bus.req;
    if (owner_m >= 0 && !r[owner_m] && !lock_of(owner_m)) owner_m = -1;
    w = owner_m >= 0 ? (r[owner_m] ? owner_m : -1)
      : r == 2'b11 ? 1 - last_m : r[0] ? 0 : r[1] ? 1 : -1;
    if (w < 0) return;
    e_gnt[w] = 1'b1;
    e_addr = bus.addr[w];
    e_wdata = bus.wdata[w];
    e_rd = !bus.we[w];
    e_wr = bus.we[w];
    if (bus.we[w]) ref_mem[e_addr] = e_wdata;
    else begin
      p_rv[w] = 1'b1;
      p_data = ref_mem[e_addr];
    end
    last_m = w;
    owner_m = lock_of(w) ? w : -1;
  endtask
  task automatic compare();
    cyc++;
    check("gnt", bus.gnt, e_gnt);
    check("mem_read", bus.mem_read, e_rd);
    check("mem_write", bus.mem_write, e_wr);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("rvalid", bus.rvalid, e_rv);
    check("rdata0", bus.rdata[0], e_rdata[0]);
    check("rdata1", bus.rdata[1], e_rdata[1]);
    if (|bus.gnt) begin
      glog.push_back(int'(bus.gnt[1]));
      gcyc.push_back(cyc);
    end
    for (int i = 0; i < 2; i++) if (bus.rvalid[i]) rlog.push_back(bus.rdata[i]);
  endtask
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (e_gnt[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (q[i].size() != 0) begin
        bus.req[i] = 1'b1;
        bus.we[i] = q[i][0].we;
        bus.addr[i] = q[i][0].addr;
        bus.wdata[i] = q[i][0].wdata;
      end else begin
        bus.req[i] = 1'b0;
        bus.we[i] = 1'($urandom);
        bus.addr[i] = AW'($urandom);
        bus.wdata[i] = DW'($urandom);
      end
`ifdef MEM_ARB_LOCK_EN
      bus.lock[i] = q[i].size() != 0 ? q[i][0].lk : 1'b0;
`endif
    end
  endtask
  task automatic step();
    predict();
    @(negedge clk);
    compare();
    drive();
  endtask
  task automatic push(int i, logic we, logic lk, logic [AW-1:0] a, logic [DW-1:0] d);
    q[i].push_back(txn_t'{we, lk, a, d});
  endtask
  task automatic drain();
    for (int n = 0; n < 300 && (q[0].size() != 0 || q[1].size() != 0 || e_gnt != 0 || p_rv != 0 || e_rv != 0); n++)
      step();
    check("drain", q[0].size() + q[1].size(), 0);
    step();
  endtask
  task automatic clear_logs();
    glog.delete(); gcyc.delete(); rlog.delete();
  endtask
  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a] = DW'($urandom);
      ref_mem[a] = mem[a];
    end
    mem[16'h0010] = 8'hA5;
    ref_mem[16'h0010] = 8'hA5;
    model_reset();
    drive();
    repeat (2) step();
    rst_n = 1'b1;
    // both requesters pending from reset: strict alternation starting with 0
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 1'b0, AW'($urandom_range(32, 255)), '0);
      push(1, 1'b0, 1'b0, AW'($urandom_range(32, 255)), '0);
    end
    drive();
    drain();
    check("cont_n", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) check("cont_alt", glog[k], k % 2);
    for (int k = 1; k < gcyc.size(); k++) check("cont_gap", gcyc[k] - gcyc[k-1], 2);
    clear_logs();
    push(0, 1'b0, 1'b0, 16'h0010, '0);
    drive();
    drain();
    check("rd_n", glog.size(), 1);
    check("rd_data", bus.rdata[0], 8'hA5);
    clear_logs();
    push(1, 1'b1, 1'b0, 16'h0FFF, 8'h3C);
    drive();
    drain();
    check("wr_n", glog.size(), 1);
    check("wr_rv", rlog.size(), 0);
    check("wr_mem", mem[16'h0FFF], 8'h3C);
    clear_logs();
    for (int k = 0; k < 3; k++) push(0, 1'b0, 1'b0, AW'(k), '0);
    drive();
    drain();
    check("b2b_n", glog.size(), 3);
    check("b2b_rv", rlog.size(), 3);
    for (int k = 0; k < rlog.size(); k++) check("b2b_data", rlog[k], ref_mem[k]);
    for (int k = 1; k < gcyc.size(); k++) check("b2b_gap", gcyc[k] - gcyc[k-1], 2);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++)
        if (q[i].size() == 0 && $urandom_range(0, 2) == 0)
          push(i, 1'($urandom), 1'b0, AW'($urandom_range(0, 31)), DW'($urandom));
      drive();
      step();
    end
    drain();
    // reset lands while a read by requester 1 is in its issue cycle
    push(1, 1'b0, 1'b0, 16'h0005, '0);
    drive();
    for (int n = 0; n < 10 && e_gnt == 0; n++) step();
    check("mid_gnt", bus.gnt, 2'b10);
    rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    drive();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    clear_logs();
    push(0, 1'b0, 1'b0, 16'h0020, '0);
    push(1, 1'b0, 1'b0, 16'h0021, '0);
    drive();
    drain();
    check("tie_n", glog.size(), 2);
    for (int k = 0; k < glog.size(); k++) check("tie_order", glog[k], k);
`ifdef MEM_ARB_LOCK_EN
    clear_logs();
    for (int k = 0; k < 4; k++) push(0, 1'b0, 1'b1, AW'(k + 8), '0);
    push(1, 1'b0, 1'b0, 16'h0030, '0);
    drive();
    drain();
    check("lock_n", glog.size(), 5);
    for (int k = 0; k < glog.size(); k++) check("lock_order", glog[k], k == 4 ? 1 : 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
